// File: rtl/ysyx_23060180_pkg.sv
// Shared types and constants for the ysyx_23060180 memory arbiter.
package ysyx_23060180_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } arb_state_t;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    // Size codes carried on mem_wbit_en.
    localparam logic [3:0] WBIT_BYTE = 4'd1;
    localparam logic [3:0] WBIT_HALF = 4'd2;
    localparam logic [3:0] WBIT_WORD = 4'd4;

endpackage

// File: rtl/ysyx_23060180_arb_prio.sv
// LSU-first priority decision with a streak limit that forces the IFU through
// after MAX_LSU_STREAK consecutive LSU wins against a waiting fetch.
module ysyx_23060180_arb_prio
    import ysyx_23060180_pkg::*;
#(
    parameter int MAX_LSU_STREAK = 4
) (
    input  logic clk,
    input  logic rstn_in,
    input  logic arb_en,
    input  logic ifu_req,
    input  logic lsu_req,
    output logic sel_ifu,
    output logic sel_lsu
);

    localparam int SW = $clog2(MAX_LSU_STREAK + 1);

    logic [SW-1:0] r_streak;
    logic          w_below;

    assign w_below = r_streak < SW'(MAX_LSU_STREAK);
    assign sel_lsu = arb_en && lsu_req && (!ifu_req || w_below);
    assign sel_ifu = arb_en && ifu_req && !sel_lsu;

    // NOTE: state updates use <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            r_streak <= '0;
        end else if (!ifu_req || sel_ifu) begin
            r_streak <= '0;
        end else if (sel_lsu) begin
            // sel_lsu with ifu_req pending implies w_below, so this saturates.
            r_streak <= r_streak + 1'b1;
        end
    end

endmodule

// File: rtl/ysyx_23060180_mem_arbiter.sv
// Shares one fixed-latency memory port between IFU reads and LSU reads/writes,
// with at most one read outstanding and back-to-back issue on the final wait cycle.
module ysyx_23060180_mem_arbiter
    import ysyx_23060180_pkg::*;
#(
    parameter int RD_LAT         = 1,
    parameter int MAX_LSU_STREAK = 4
) (
    input  logic        clk,
    input  logic        rstn_in,
    input  logic        ifu_req,
    input  logic [31:0] ifu_addr,
    output logic        ifu_gnt,
    output logic        ifu_rvalid,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wbit_en,
    output logic        lsu_gnt,
    output logic        lsu_rvalid,
    output logic [31:0] lsu_rdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wbit_en,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = $clog2(RD_LAT + 1);

    arb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_owner;

    logic w_final;
    logic w_arb_en;
    logic w_sel_ifu;
    logic w_sel_lsu;
    logic w_rd_issue;
    logic w_wr_issue;

    assign w_final    = (r_state == RD_WAIT) && (r_cnt == CNT_W'(1));
    // Gating with rstn_in keeps every output at 0 while reset is held.
    assign w_arb_en   = rstn_in && ((r_state == IDLE) || w_final);
    assign w_rd_issue = w_sel_ifu || (w_sel_lsu && !lsu_we);
    assign w_wr_issue = w_sel_lsu && lsu_we;

    ysyx_23060180_arb_prio #(
        .MAX_LSU_STREAK(MAX_LSU_STREAK)
    ) u_prio (
        .clk     (clk),
        .rstn_in (rstn_in),
        .arb_en  (w_arb_en),
        .ifu_req (ifu_req),
        .lsu_req (lsu_req),
        .sel_ifu (w_sel_ifu),
        .sel_lsu (w_sel_lsu)
    );

    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_owner <= OWN_IFU;
        end else if (w_rd_issue) begin
            r_state <= RD_WAIT;
            r_cnt   <= CNT_W'(RD_LAT);
            r_owner <= w_sel_lsu ? OWN_LSU : OWN_IFU;
        end else if (w_final) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (r_state == RD_WAIT) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // NOTE: defaults at the top of always_comb prevent latch inference.
    always_comb begin
        ifu_gnt     = w_sel_ifu;
        lsu_gnt     = w_sel_lsu;
        mem_rd      = w_rd_issue;
        mem_wr      = w_wr_issue;
        mem_raddr   = '0;
        mem_wdata   = '0;
        mem_wbit_en = '0;
        if (w_sel_ifu) begin
            mem_raddr = ifu_addr;
        end else if (w_sel_lsu) begin
            mem_raddr = lsu_addr;
        end
        if (w_wr_issue) begin
            mem_wdata   = lsu_wdata;
            mem_wbit_en = lsu_wbit_en;
        end
        ifu_rvalid = w_final && (r_owner == OWN_IFU);
        lsu_rvalid = w_final && (r_owner == OWN_LSU);
        ifu_rdata  = ifu_rvalid ? mem_rdata : '0;
        lsu_rdata  = lsu_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_ysyx_23060180_mem_arbiter.sv
// Two arbiter lanes (RD_LAT=1 and RD_LAT=3) driven from a shared stimulus loop and
// scored against a cycle-budget reference model through expectation queues.
module tb_ysyx_23060180_mem_arbiter;
    import ysyx_23060180_pkg::*;

    localparam int MAXS = 4;

    typedef struct {
        bit          ifu;
        bit          lsu;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wbe;
        int          cyc;
    } iss_t;

    typedef struct {
        bit          is_lsu;
        logic [31:0] data;
        int          cyc;
    } rsp_t;

    logic clk = 1'b0;
    logic rstn_in = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  ifu_req, ifu_gnt, ifu_rvalid, lsu_req, lsu_we, lsu_gnt, lsu_rvalid, mem_rd, mem_wr;
    logic [31:0] ifu_addr [2];
    logic [31:0] ifu_rdata [2];
    logic [31:0] lsu_addr [2];
    logic [31:0] lsu_wdata [2];
    logic [3:0]  lsu_wbit_en [2];
    logic [31:0] lsu_rdata [2];
    logic [31:0] mem_raddr [2];
    logic [31:0] mem_wdata [2];
    logic [3:0]  mem_wbit_en [2];
    logic [31:0] mem_rdata [2];

    ysyx_23060180_mem_arbiter #(.RD_LAT(1), .MAX_LSU_STREAK(MAXS)) u_dut_lat1 (
        .clk(clk), .rstn_in(rstn_in),
        .ifu_req(ifu_req[0]), .ifu_addr(ifu_addr[0]), .ifu_gnt(ifu_gnt[0]),
        .ifu_rvalid(ifu_rvalid[0]), .ifu_rdata(ifu_rdata[0]),
        .lsu_req(lsu_req[0]), .lsu_we(lsu_we[0]), .lsu_addr(lsu_addr[0]),
        .lsu_wdata(lsu_wdata[0]), .lsu_wbit_en(lsu_wbit_en[0]), .lsu_gnt(lsu_gnt[0]),
        .lsu_rvalid(lsu_rvalid[0]), .lsu_rdata(lsu_rdata[0]),
        .mem_rd(mem_rd[0]), .mem_wr(mem_wr[0]), .mem_raddr(mem_raddr[0]),
        .mem_wdata(mem_wdata[0]), .mem_wbit_en(mem_wbit_en[0]), .mem_rdata(mem_rdata[0])
    );

    ysyx_23060180_mem_arbiter #(.RD_LAT(3), .MAX_LSU_STREAK(MAXS)) u_dut_lat3 (
        .clk(clk), .rstn_in(rstn_in),
        .ifu_req(ifu_req[1]), .ifu_addr(ifu_addr[1]), .ifu_gnt(ifu_gnt[1]),
        .ifu_rvalid(ifu_rvalid[1]), .ifu_rdata(ifu_rdata[1]),
        .lsu_req(lsu_req[1]), .lsu_we(lsu_we[1]), .lsu_addr(lsu_addr[1]),
        .lsu_wdata(lsu_wdata[1]), .lsu_wbit_en(lsu_wbit_en[1]), .lsu_gnt(lsu_gnt[1]),
        .lsu_rvalid(lsu_rvalid[1]), .lsu_rdata(lsu_rdata[1]),
        .mem_rd(mem_rd[1]), .mem_wr(mem_wr[1]), .mem_raddr(mem_raddr[1]),
        .mem_wdata(mem_wdata[1]), .mem_wbit_en(mem_wbit_en[1]), .mem_rdata(mem_rdata[1])
    );

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    // Pending requests, held on the pins until the model says they are granted.
    bit          p_ifu [2];
    logic [31:0] p_ifu_addr [2];
    bit          p_lsu [2];
    bit          p_we [2];
    logic [31:0] p_lsu_addr [2];
    logic [31:0] p_wdata [2];
    logic [3:0]  p_wbe [2];

    // Reference model: earliest cycle a grant may issue, and LSU wins against a waiting fetch.
    int free_at [2];
    int streak [2];

    int          mem_due [2];
    logic [31:0] mem_val [2];

    iss_t iss_q [2][$];
    rsp_t rsp_q [2][$];

    function automatic int lat(int l);
        return (l == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] memval(logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0010_0073;
        return {a[15:0], ~a[31:16]} ^ 32'h5a5a_0f0f;
    endfunction

    task automatic check(string name, int l, logic [95:0] act, logic [95:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s lane%0d cyc=%0d got=%0h expected=%0h", name, l, cyc, act, exp);
    endtask

    task automatic post_ifu(int l, logic [31:0] a);
        p_ifu[l] = 1'b1;
        p_ifu_addr[l] = a;
    endtask

    task automatic post_lsu(int l, bit we, logic [31:0] a, logic [31:0] d, logic [3:0] b);
        p_lsu[l] = 1'b1;
        p_we[l] = we;
        p_lsu_addr[l] = a;
        p_wdata[l] = d;
        p_wbe[l] = b;
    endtask

    task automatic model(int l);
        bit g_ifu, g_lsu;
        iss_t e;
        rsp_t r;
        if (!rstn_in) begin
            streak[l] = 0;
            free_at[l] = 0;
            rsp_q[l].delete();
            return;
        end
        g_lsu = (cyc >= free_at[l]) && p_lsu[l] && (!p_ifu[l] || streak[l] < MAXS);
        g_ifu = (cyc >= free_at[l]) && p_ifu[l] && !g_lsu;
        if (!p_ifu[l] || g_ifu) streak[l] = 0;
        else if (g_lsu) streak[l] = (streak[l] + 1 > MAXS) ? MAXS : streak[l] + 1;
        if (!(g_ifu || g_lsu)) return;
        e.ifu = g_ifu;
        e.lsu = g_lsu;
        e.wr = g_lsu && p_we[l];
        e.rd = !e.wr;
        e.addr = g_ifu ? p_ifu_addr[l] : p_lsu_addr[l];
        e.wdata = e.wr ? p_wdata[l] : 32'h0;
        e.wbe = e.wr ? p_wbe[l] : 4'h0;
        e.cyc = cyc;
        iss_q[l].push_back(e);
        if (e.rd) begin
            r.is_lsu = g_lsu;
            r.data = memval(e.addr);
            r.cyc = cyc + lat(l);
            rsp_q[l].push_back(r);
            free_at[l] = cyc + lat(l);
        end
        if (g_ifu) p_ifu[l] = 1'b0;
        if (g_lsu) p_lsu[l] = 1'b0;
    endtask

    // Drives one cycle's inputs (garbage on idle fields), runs the model, advances a cycle.
    task automatic step();
        for (int l = 0; l < 2; l++) begin
            ifu_req[l] = p_ifu[l];
            ifu_addr[l] = p_ifu[l] ? p_ifu_addr[l] : $urandom();
            lsu_req[l] = p_lsu[l];
            lsu_we[l] = p_lsu[l] ? p_we[l] : 1'($urandom());
            lsu_addr[l] = p_lsu[l] ? p_lsu_addr[l] : $urandom();
            lsu_wdata[l] = p_lsu[l] ? p_wdata[l] : $urandom();
            lsu_wbit_en[l] = p_lsu[l] ? p_wbe[l] : 4'($urandom());
            mem_rdata[l] = (mem_due[l] == cyc) ? mem_val[l] : $urandom();
            model(l);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [3:0] rand_wbe();
        case ($urandom_range(2))
            0: return WBIT_BYTE;
            1: return WBIT_HALF;
            default: return WBIT_WORD;
        endcase
    endfunction

    // Monitor: pops expectations whenever the DUT presents a grant or response.
    always @(negedge clk) begin
        iss_t e;
        rsp_t r;
        for (int l = 0; l < 2; l++) begin
            if (ifu_gnt[l] || lsu_gnt[l]) begin
                if (iss_q[l].size() > 0 && iss_q[l][0].cyc == cyc) begin
                    e = iss_q[l].pop_front();
                    check("gnt", l, 96'({ifu_gnt[l], lsu_gnt[l]}), 96'({e.ifu, e.lsu}));
                    check("mem_rd_wr", l, 96'({mem_rd[l], mem_wr[l]}), 96'({e.rd, e.wr}));
                    check("mem_raddr", l, 96'(mem_raddr[l]), 96'(e.addr));
                    check("mem_wdata", l, 96'(mem_wdata[l]), 96'(e.wdata));
                    check("mem_wbit_en", l, 96'(mem_wbit_en[l]), 96'(e.wbe));
                end else begin
                    check("unexpected_gnt", l, 96'({ifu_gnt[l], lsu_gnt[l]}), 96'(0));
                end
            end else begin
                if (iss_q[l].size() > 0 && iss_q[l][0].cyc == cyc) begin
                    e = iss_q[l].pop_front();
                    check("missing_gnt", l, 96'({ifu_gnt[l], lsu_gnt[l]}), 96'({e.ifu, e.lsu}));
                end
                check("idle_port", l,
                      96'({mem_rd[l], mem_wr[l], mem_raddr[l], mem_wdata[l], mem_wbit_en[l]}), 96'(0));
            end
            if (rsp_q[l].size() > 0 && rsp_q[l][0].cyc == cyc) begin
                r = rsp_q[l].pop_front();
                check("rvalid", l, 96'({ifu_rvalid[l], lsu_rvalid[l]}), 96'({!r.is_lsu, r.is_lsu}));
                check("ifu_rdata", l, 96'(ifu_rdata[l]), r.is_lsu ? 96'(0) : 96'(r.data));
                check("lsu_rdata", l, 96'(lsu_rdata[l]), r.is_lsu ? 96'(r.data) : 96'(0));
            end else begin
                check("rvalid_idle", l,
                      96'({ifu_rvalid[l], lsu_rvalid[l], ifu_rdata[l], lsu_rdata[l]}), 96'(0));
            end
            if (mem_rd[l]) begin
                mem_due[l] = cyc + lat(l);
                mem_val[l] = memval(mem_raddr[l]);
            end
        end
    end

    initial begin
        for (int l = 0; l < 2; l++) begin
            p_ifu[l] = 1'b0;
            p_lsu[l] = 1'b0;
            free_at[l] = 0;
            streak[l] = 0;
            mem_due[l] = -1;
        end
        ifu_req = '0;
        lsu_req = '0;
        @(posedge clk);
        #1;

        // Reset with a fetch already pending: nothing may issue until release.
        for (int l = 0; l < 2; l++) post_ifu(l, 32'h8000_0000);
        idle(3);
        rstn_in = 1'b1;
        idle(5);

        // Collision: LSU read wins, IFU follows back-to-back on the final wait cycle.
        for (int l = 0; l < 2; l++) begin
            post_ifu(l, 32'h8000_0004);
            post_lsu(l, 1'b0, 32'h8000_1000, 32'h0, 4'h0);
        end
        idle(10);

        // Starvation: continuous LSU writes against a waiting fetch.
        for (int i = 0; i < 24; i++) begin
            for (int l = 0; l < 2; l++) begin
                if (!p_lsu[l]) post_lsu(l, 1'b1, 32'h8000_2000 + 32'(i * 4), $urandom(), rand_wbe());
                if (!p_ifu[l]) post_ifu(l, 32'h8000_0100 + 32'(i * 4));
            end
            step();
        end
        for (int l = 0; l < 2; l++) p_lsu[l] = 1'b0;
        idle(6);

        // Single word write: no read response may follow.
        for (int l = 0; l < 2; l++) post_lsu(l, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, WBIT_WORD);
        idle(5);

        // Reset mid-read: the outstanding response is discarded.
        for (int l = 0; l < 2; l++) post_ifu(l, 32'h8000_0040);
        step();
        rstn_in = 1'b0;
        idle(2);
        rstn_in = 1'b1;
        idle(5);
        for (int l = 0; l < 2; l++) post_ifu(l, 32'h8000_0000);
        idle(5);

        // Randomized traffic, including dropped requests and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rstn_in = !((i % 700) inside {350, 351});
            for (int l = 0; l < 2; l++) begin
                if (p_ifu[l] && $urandom_range(19) == 0) p_ifu[l] = 1'b0;
                else if (!p_ifu[l] && $urandom_range(2) == 0)
                    post_ifu(l, 32'h8000_0000 + 32'($urandom_range(255) * 4));
                if (p_lsu[l] && $urandom_range(19) == 0) p_lsu[l] = 1'b0;
                else if (!p_lsu[l] && $urandom_range(1) == 0)
                    post_lsu(l, 1'($urandom()), 32'h8001_0000 + 32'($urandom_range(1023)),
                             $urandom(), rand_wbe());
            end
            step();
        end
        rstn_in = 1'b1;
        for (int l = 0; l < 2; l++) begin
            p_ifu[l] = 1'b0;
            p_lsu[l] = 1'b0;
        end
        idle(8);
        for (int l = 0; l < 2; l++) begin
            check("drain_rsp", l, 96'(rsp_q[l].size()), 96'(0));
            check("drain_gnt", l, 96'(iss_q[l].size()), 96'(0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ysyx_23060180_mem_arbiter.md
# ysyx_23060180_mem_arbiter

Shares the core's single fixed-latency memory port between the instruction-fetch requester (IFU, read-only) and the load/store requester (LSU, read/write). LSU has fixed priority, with a streak limit that bounds IFU starvation. Only one read is outstanding at a time. The block sits between the core's fetch and load/store logic and the memory model or bus bridge.

## Interface
- `RD_LAT`, default 1: cycles from read issue (`mem_rd`=1) to valid `mem_rdata`; must be ≥1.
- `MAX_LSU_STREAK`, default 4: consecutive LSU grants allowed while `ifu_req` is pending before the IFU is forced; must be ≥1.
- `clk  in  1`: single clock, rising edge.
- `rstn_in  in  1`: reset, asynchronous, active-low.
- `ifu_req  in  1`: IFU read request; held until `ifu_gnt`.
- `ifu_addr  in  32`: IFU read address.
- `ifu_gnt  out  1`: IFU request issued this cycle.
- `ifu_rvalid  out  1`: IFU read data valid (one-cycle pulse).
- `ifu_rdata  out  32`: IFU read data; 0 when `ifu_rvalid`=0.
- `lsu_req  in  1`: LSU request; held until `lsu_gnt`.
- `lsu_we  in  1`: 1 = write, 0 = read.
- `lsu_addr  in  32`: LSU address.
- `lsu_wdata  in  32`: write data.
- `lsu_wbit_en  in  4`: write size code (1 = byte, 2 = half, 4 = word); passed through unchanged.
- `lsu_gnt  out  1`: LSU request issued this cycle.
- `lsu_rvalid  out  1`: LSU read data valid (one-cycle pulse; never pulses for writes).
- `lsu_rdata  out  32`: LSU read data; 0 when `lsu_rvalid`=0.
- `mem_rd  out  1`, `mem_wr  out  1`, `mem_raddr  out  32`, `mem_wdata  out  32`, `mem_wbit_en  out  4`: memory port.
- `mem_rdata  in  32`: memory read data, valid `RD_LAT` cycles after `mem_rd`.

## Operation
- States:
  - IDLE: may issue.
  - RD_WAIT: read outstanding; the latency counter counts down from `RD_LAT`.
- Arbitration happens in IDLE, and in the final RD_WAIT cycle (the cycle in which `rvalid` pulses), which gives back-to-back reads.
- Arbitration rule:
  - If `lsu_req` and (`ifu_req`=0 or streak < `MAX_LSU_STREAK`), grant the LSU.
  - Else if `ifu_req`, grant the IFU.
  - Else no grant.
- Grant and issue are combinational and happen in the same cycle:
  - `gnt`=1.
  - `mem_rd` or `mem_wr` is driven.
  - `mem_raddr` = the winner's address.
  - On LSU writes, `mem_wdata` = `lsu_wdata` and `mem_wbit_en` = `lsu_wbit_en`.
- When no write is issued, `mem_wdata` and `mem_wbit_en` are 0.
- When nothing is issued, `mem_rd`, `mem_wr` and `mem_raddr` are 0.
- A read grant registers the owner (IFU/LSU) and moves the FSM to RD_WAIT with counter = `RD_LAT`.
- When the counter reaches 1:
  - `owner_rvalid`=1 and `owner_rdata` = `mem_rdata`.
  - The FSM returns to IDLE, unless a new read is granted in the same cycle.
- A write grant leaves the FSM in IDLE. The write completes on its grant cycle, and another grant is possible the next cycle.
- No grant is issued in non-final RD_WAIT cycles. Held requests stay pending.
- Streak counter:
  - Increments on each LSU grant while `ifu_req`=1.
  - Clears on any IFU grant, and in any cycle with `ifu_req`=0.
  - Saturates at `MAX_LSU_STREAK`.
- Requests that drop before their grant are simply not served. There is no error.

## Timing
- Reset (asynchronous): state IDLE, counter 0, owner cleared, streak 0. Every output is 0.
- Reset mid-read: the outstanding response is discarded, and no `rvalid` follows reset release.
- Read latency: `gnt` at cycle T, `rvalid` at T+`RD_LAT`. Maximum read throughput is one read per `RD_LAT` cycles.
- Write: `gnt` and `mem_wr` at T. Next grant possible at T+1.
- Simultaneous requests with streak < `MAX_LSU_STREAK`: the LSU wins. With streak = `MAX_LSU_STREAK`: the IFU wins.
- `ifu_gnt` and `lsu_gnt` are never both 1. `mem_rd` and `mem_wr` are never both 1.

## Structure
- Shared package `ysyx_23060180_pkg`:
  - `arb_state_t` enum {IDLE, RD_WAIT}.
  - Owner localparams `OWN_IFU` = 0, `OWN_LSU` = 1.
  - The `mem_wbit_en` size-code localparams.
- One sub-module, `ysyx_23060180_arb_prio`: combinational priority decision plus the registered streak counter. Outputs `sel_ifu` and `sel_lsu`.
- The FSM, latency counter, owner register and port muxing live in the top.

## Test plan
- Reset: `rstn_in`=0 → all outputs 0. Release, then `ifu_req`=1 with `ifu_addr`=0x80000000 → `ifu_gnt`=1 and `mem_rd`=1 with `mem_raddr`=0x80000000 at T. At T+1 (`RD_LAT`=1), `ifu_rvalid`=1 and `ifu_rdata` = `mem_rdata` = 0x00100073.
- Collision: `ifu_req` and `lsu_req` (read, 0x80001000) both asserted at T → `lsu_gnt` at T and `lsu_rvalid` at T+1. `ifu_gnt` at T+1 (back-to-back) and `ifu_rvalid` at T+2.
- Starvation: `lsu_req`=1 continuously with `lsu_we`=1 and `ifu_req`=1 (`MAX_LSU_STREAK`=4) → 4 `lsu_gnt` pulses, then `ifu_gnt`, then LSU grants resume.
- Write: `lsu_we`=1, `lsu_addr`=0x80000010, `lsu_wdata`=0xDEADBEEF, `lsu_wbit_en`=4 → `mem_wr`=1 with those values at the grant cycle, and `lsu_rvalid` is never asserted.
- `RD_LAT`=3: a read granted at T → no grants at T+1 and T+2. `rvalid` at T+3.
- Reset mid-read: a read granted at T, then `rstn_in` low at T+1 (`RD_LAT`=3) → no `rvalid` ever appears. After release the first grant behaves as in the reset scenario.
